// File: rtl/qspi_register_bridge.sv
// rtl/qspi_register_bridge.sv - QSPI instruction sequencer onto a byte-wide register bus
module qspi_register_bridge #(
  parameter logic [7:0] OP_WRITE       = 8'h02,
  parameter logic [7:0] OP_READ        = 8'h03,
  parameter logic [7:0] OP_STATUS      = 8'h05,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qspi_start,
  input  logic        qspi_stop,
  input  logic        qspi_insn_valid,
  input  logic [23:0] qspi_insn,
  input  logic        qspi_wr_valid,
  input  logic [7:0]  qspi_wr_data,
  output logic        qspi_rd_mode,
  input  logic        qspi_rd_ready,
  output logic        qspi_rd_valid,
  output logic [7:0]  qspi_rd_data,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  input  logic        bus_rd_valid,
  input  logic [7:0]  bus_rd_data,
  output logic        status_timeout,
  output logic        status_overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WRITE, S_RD_IDLE, S_RD_WAIT, S_STATUS, S_DISCARD
  } state_t;

  state_t          state;
  logic [15:0]     addr;
  logic            rd_mode_ff;
  logic            pending;
  logic [CW-1:0]   tmo_cnt;
  logic            stat_valid;
  logic [7:0]      stat_data;

  logic [7:0]      opcode;
  logic            insn_is_rd;
  logic            abort;
  logic            in_wait;
  logic            rd_hit;
  logic            tmo_hit;
  logic            rd_done;
  logic            set_ovf;
  logic            stat_rd;

  assign opcode     = qspi_insn[23:16];
  assign insn_is_rd = (opcode == OP_READ) || (opcode == OP_STATUS);

  // Direction must be known in the same cycle the instruction lands
  assign qspi_rd_mode = qspi_insn_valid ? insn_is_rd : rd_mode_ff;

  // A start or stop kills any outstanding read, so its completion is never forwarded
  assign abort   = qspi_stop | qspi_start;
  assign in_wait = (state == S_RD_WAIT) && !abort;
  assign rd_hit  = in_wait && bus_rd_valid;
  assign tmo_hit = in_wait && !bus_rd_valid && (tmo_cnt == CW'(TIMEOUT_CYCLES));
  assign rd_done = rd_hit | tmo_hit;
  assign set_ovf = in_wait && !rd_done && qspi_rd_ready && pending;
  assign stat_rd = (state == S_STATUS) && qspi_rd_ready && !abort;

  // Read bytes pass straight through from the bus; timeout and status bytes are muxed in
  assign qspi_rd_valid = rd_hit | tmo_hit | stat_valid;
  assign qspi_rd_data  = rd_hit     ? bus_rd_data  :
                         tmo_hit    ? TIMEOUT_DATA :
                         stat_valid ? stat_data    : 8'h00;

  // Command FSM, register bus strobes and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      addr            <= 16'h0000;
      rd_mode_ff      <= 1'b0;
      pending         <= 1'b0;
      tmo_cnt         <= '0;
      stat_valid      <= 1'b0;
      stat_data       <= 8'h00;
      bus_wr_en       <= 1'b0;
      bus_rd_en       <= 1'b0;
      bus_addr        <= 16'h0000;
      bus_wr_data     <= 8'h00;
      status_timeout  <= 1'b0;
      status_overflow <= 1'b0;
    end else begin
      bus_wr_en  <= 1'b0;
      bus_rd_en  <= 1'b0;
      stat_valid <= 1'b0;

      // A status read clears the sticky bits, but a new event in the same cycle wins
      status_timeout  <= (status_timeout  & ~stat_rd) | tmo_hit;
      status_overflow <= (status_overflow & ~stat_rd) | set_ovf;

      // A write byte arriving together with stop is still committed
      if (state == S_WRITE && qspi_wr_valid) begin
        bus_wr_en   <= 1'b1;
        bus_addr    <= addr;
        bus_wr_data <= qspi_wr_data;
        addr        <= addr + 16'd1;
      end

      if (qspi_stop) begin
        state      <= S_IDLE;
        pending    <= 1'b0;
        tmo_cnt    <= '0;
        rd_mode_ff <= 1'b0;
      end else if (qspi_start) begin
        state      <= S_CMD;
        pending    <= 1'b0;
        tmo_cnt    <= '0;
        rd_mode_ff <= 1'b0;
      end else begin
        case (state)
          S_CMD: begin
            if (qspi_insn_valid) begin
              addr       <= qspi_insn[15:0];
              rd_mode_ff <= insn_is_rd;
              if (opcode == OP_WRITE)       state <= S_WRITE;
              else if (opcode == OP_READ)   state <= S_RD_IDLE;
              else if (opcode == OP_STATUS) state <= S_STATUS;
              else                          state <= S_DISCARD;
            end
          end
          S_RD_IDLE: begin
            if (qspi_rd_ready) begin
              bus_rd_en <= 1'b1;
              bus_addr  <= addr;
              addr      <= addr + 16'd1;
              tmo_cnt   <= '0;
              state     <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (rd_done) begin
              // A queued request is issued immediately; a fresh one then becomes the queued one
              if (pending || qspi_rd_ready) begin
                bus_rd_en <= 1'b1;
                bus_addr  <= addr;
                addr      <= addr + 16'd1;
                tmo_cnt   <= '0;
                pending   <= pending & qspi_rd_ready;
              end else begin
                state <= S_RD_IDLE;
              end
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
              if (qspi_rd_ready) pending <= 1'b1;
            end
          end
          S_STATUS: begin
            if (qspi_rd_ready) begin
              stat_valid <= 1'b1;
              stat_data  <= {6'b000000, status_overflow, status_timeout};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_register_bridge.sv
// tb/tb_qspi_register_bridge.sv - scoreboard bench for qspi_register_bridge
module tb_qspi_register_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qspi_start = 1'b0;
  logic        qspi_stop = 1'b0;
  logic        qspi_insn_valid = 1'b0;
  logic [23:0] qspi_insn = 24'h0;
  logic        qspi_wr_valid = 1'b0;
  logic [7:0]  qspi_wr_data = 8'h0;
  logic        qspi_rd_mode;
  logic        qspi_rd_ready = 1'b0;
  logic        qspi_rd_valid;
  logic [7:0]  qspi_rd_data;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_rd_valid = 1'b0;
  logic [7:0]  bus_rd_data = 8'h0;
  logic        status_timeout;
  logic        status_overflow;

  qspi_register_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .qspi_start(qspi_start), .qspi_stop(qspi_stop),
    .qspi_insn_valid(qspi_insn_valid), .qspi_insn(qspi_insn),
    .qspi_wr_valid(qspi_wr_valid), .qspi_wr_data(qspi_wr_data),
    .qspi_rd_mode(qspi_rd_mode), .qspi_rd_ready(qspi_rd_ready),
    .qspi_rd_valid(qspi_rd_valid), .qspi_rd_data(qspi_rd_data),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_valid(bus_rd_valid), .bus_rd_data(bus_rd_data),
    .status_timeout(status_timeout), .status_overflow(status_overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = -1;
  int rc = 0;
  int rd_en_cyc = 0;
  int rd_valid_cyc = 0;
  logic [15:0] resp_addr = 16'h0;
  logic [23:0] wexp;
  logic [15:0] rexp;
  logic [7:0]  dexp;

  logic [23:0] wq[$];
  logic [15:0] rq[$];
  logic [7:0]  dq[$];

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: answers bus_rd_en after lat cycles, never when lat <= 0
  always @(posedge clk) begin
    #1;
    bus_rd_valid = 1'b0;
    bus_rd_data  = 8'h00;
    if (rc > 0) begin
      rc = rc - 1;
      if (rc == 0) begin
        bus_rd_valid = 1'b1;
        bus_rd_data  = mem(resp_addr);
      end
    end
    if (bus_rd_en && lat > 0) begin
      rc = lat;
      resp_addr = bus_addr;
    end
  end

  // Scoreboard: every strobe the DUT produces is matched against the expected queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_wr_en) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL bus_write unexpected: got addr=%h data=%h, expected none", bus_addr, bus_wr_data);
        end else begin
          wexp = wq.pop_front();
          if ({bus_addr, bus_wr_data} !== wexp) begin
            errors++;
            $display("FAIL bus_write: got %h_%h, expected %h_%h", bus_addr, bus_wr_data, wexp[23:8], wexp[7:0]);
          end
        end
      end
      if (bus_rd_en) begin
        rd_en_cyc = cyc;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL bus_read unexpected: got addr=%h, expected none", bus_addr);
        end else begin
          rexp = rq.pop_front();
          if (bus_addr !== rexp) begin
            errors++;
            $display("FAIL bus_read_addr: got %h, expected %h", bus_addr, rexp);
          end
        end
      end
      if (qspi_rd_valid) begin
        rd_valid_cyc = cyc;
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL qspi_rd unexpected: got data=%h, expected none", qspi_rd_data);
        end else begin
          dexp = dq.pop_front();
          if (qspi_rd_data !== dexp) begin
            errors++;
            $display("FAIL qspi_rd_data: got %h, expected %h", qspi_rd_data, dexp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send_insn(input logic [7:0] op, input logic [15:0] a);
    logic exp_mode;
    exp_mode = (op == 8'h03) || (op == 8'h05);
    step();
    qspi_start = 1'b1;
    step();
    qspi_start = 1'b0;
    qspi_insn_valid = 1'b1;
    qspi_insn = {op, a};
    @(negedge clk);
    checks++;
    if (qspi_rd_mode !== exp_mode) begin
      errors++;
      $display("FAIL rd_mode op=%h: got %b, expected %b", op, qspi_rd_mode, exp_mode);
    end
    step();
    qspi_insn_valid = 1'b0;
  endtask

  task automatic end_txn();
    step();
    qspi_stop = 1'b1;
    step();
    qspi_stop = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    step();
    qspi_wr_valid = 1'b1;
    qspi_wr_data = b;
    step();
    qspi_wr_valid = 1'b0;
  endtask

  task automatic rd_pulse();
    step();
    qspi_rd_ready = 1'b1;
    step();
    qspi_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_wr_en, bus_rd_en, qspi_rd_valid, qspi_rd_mode} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 0000", {bus_wr_en, bus_rd_en, qspi_rd_valid, qspi_rd_mode});
    end
    checks++;
    if ({bus_addr, bus_wr_data, qspi_rd_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", {bus_addr, bus_wr_data, qspi_rd_data});
    end
    checks++;
    if ({status_timeout, status_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got %b, expected 00", {status_timeout, status_overflow});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    send_insn(8'h02, 16'h1234);
    wq.push_back({16'h1234, 8'hA5});
    wr_byte(8'hA5);
    wq.push_back({16'h1235, 8'h5A});
    wr_byte(8'h5A);
    wait_cycles(3);
    end_txn();
    wait_cycles(2);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL write_drain: got %0d writes missing, expected 0", wq.size());
    end
  endtask

  task automatic test_read_wrap();
    lat = 3;
    send_insn(8'h03, 16'hFFFF);
    rq.push_back(16'hFFFF);
    dq.push_back(mem(16'hFFFF));
    rd_pulse();
    wait_cycles(6);
    rq.push_back(16'h0000);
    dq.push_back(mem(16'h0000));
    rd_pulse();
    wait_cycles(6);
    end_txn();
    checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL read_wrap_drain: got %0d/%0d pending, expected 0/0", rq.size(), dq.size());
    end
    lat = -1;
  endtask

  task automatic test_timeout();
    lat = -1;
    send_insn(8'h03, 16'h0010);
    rq.push_back(16'h0010);
    dq.push_back(8'hFF);
    rd_pulse();
    wait_cycles(20);
    checks++;
    if (status_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, expected 1", status_timeout);
    end
    checks++;
    if (rd_valid_cyc - rd_en_cyc != 16) begin
      errors++;
      $display("FAIL timeout_latency: got %0d, expected 16", rd_valid_cyc - rd_en_cyc);
    end
    end_txn();
    send_insn(8'h05, 16'h0000);
    dq.push_back(8'h01);
    rd_pulse();
    wait_cycles(2);
    checks++;
    if (status_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b, expected 0", status_timeout);
    end
    dq.push_back(8'h00);
    rd_pulse();
    wait_cycles(2);
    end_txn();
    checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL timeout_drain: got %0d/%0d pending, expected 0/0", rq.size(), dq.size());
    end
  endtask

  task automatic test_back_to_back();
    lat = -1;
    send_insn(8'h03, 16'h0200);
    rq.push_back(16'h0200);
    rq.push_back(16'h0201);
    dq.push_back(8'hFF);
    dq.push_back(8'hFF);
    step();
    qspi_rd_ready = 1'b1;
    wait_cycles(3);
    qspi_rd_ready = 1'b0;
    wait_cycles(40);
    checks++;
    if (status_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, expected 1", status_overflow);
    end
    end_txn();
    send_insn(8'h05, 16'h0000);
    dq.push_back(8'h03);
    rd_pulse();
    wait_cycles(2);
    checks++;
    if ({status_overflow, status_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL overflow_clear: got %b, expected 00", {status_overflow, status_timeout});
    end
    end_txn();
    checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: got %0d/%0d pending, expected 0/0", rq.size(), dq.size());
    end
  endtask

  task automatic test_discard();
    send_insn(8'h7E, 16'h0000);
    wr_byte(8'h11);
    wr_byte(8'h22);
    rd_pulse();
    wait_cycles(3);
    checks++;
    if (qspi_rd_mode !== 1'b0) begin
      errors++;
      $display("FAIL discard_rd_mode: got %b, expected 0", qspi_rd_mode);
    end
    end_txn();
  endtask

  task automatic test_stop_mid_read();
    lat = 5;
    send_insn(8'h03, 16'h0300);
    rq.push_back(16'h0300);
    rd_pulse();
    wait_cycles(2);
    end_txn();
    wait_cycles(8);
    checks++;
    if (rq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL stop_mid_read_drain: got %0d/%0d pending, expected 0/0", rq.size(), dq.size());
    end
    lat = -1;
  endtask

  task automatic test_reset_mid_read();
    lat = -1;
    send_insn(8'h03, 16'h0400);
    step();
    qspi_rd_ready = 1'b1;
    step();
    qspi_rd_ready = 1'b0;
    #1;
    checks++;
    if ({bus_rd_en, bus_addr} !== {1'b1, 16'h0400}) begin
      errors++;
      $display("FAIL pre_reset_read: got en=%b addr=%h, expected en=1 addr=0400", bus_rd_en, bus_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_wr_en, bus_rd_en, qspi_rd_valid, qspi_rd_mode, bus_addr} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: got %h, expected 0", {bus_wr_en, bus_rd_en, qspi_rd_valid, qspi_rd_mode, bus_addr});
    end
    wait_cycles(2);
    rst_n = 1'b1;
    step();
    send_insn(8'h02, 16'hABCD);
    wq.push_back({16'hABCD, 8'h77});
    wr_byte(8'h77);
    wait_cycles(3);
    end_txn();
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL post_reset_write: got %0d writes missing, expected 0", wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_timeout();
    test_back_to_back();
    test_discard();
    test_stop_mid_read();
    test_reset_mid_read();
    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
